fpu_pipe_drain: RTL and testbench

Exit-side buffer for the pipelined FPU: it captures results and their valid tags as they leave the final stage of the enable-gated pipeline delay lines. It holds those results in a small FIFO and presents them to the consumer over a valid/ready handshake. It also drives the pipeline advance enable, freezing every stage whenever the FIFO has no room, so back-pressure never drops or duplicates a result.

---
 rtl/fpu_pipe_drain_if.sv | 32 +++
 rtl/fpu_pipe_drain.sv | 65 ++++++
 tb/tb_fpu_pipe_drain.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_pipe_drain_if.sv
// Exit-side bus of the FPU pipeline drain buffer: the pipeline capture side
// (valid tag, result, advance enable, flush) and the consumer result side.
//
// Handshake: a result transfers on a rising edge where res_valid_o && res_ready_i.
// While res_valid_o is high and res_ready_i is low, res_data_o holds steady.
// res_valid_o never depends on res_ready_i.
// On the capture side, a result is taken on an edge where pipe_en_o && pipe_valid_i.
interface fpu_pipe_drain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                     pipe_valid_i;
    logic [WIDTH-1:0]         pipe_data_i;
    logic                     pipe_en_o;
    logic                     flush_i;
    logic                     res_valid_o;
    logic [WIDTH-1:0]         res_data_o;
    logic                     res_ready_i;
    logic [$clog2(DEPTH):0]   count_o;

    // Buffer side: receives pipeline results, presents them to the consumer.
    modport slave (
        input  pipe_valid_i, pipe_data_i, flush_i, res_ready_i,
        output pipe_en_o, res_valid_o, res_data_o, count_o
    );

    // Environment side: pipeline plus consumer.
    modport master (
        output pipe_valid_i, pipe_data_i, flush_i, res_ready_i,
        input  pipe_en_o, res_valid_o, res_data_o, count_o
    );
endinterface

// File: rtl/fpu_pipe_drain.sv
// Drain FIFO at the exit of the enable-gated FPU pipeline. It captures the
// results, buffers them in a circular FIFO, and hands them to the consumer.
// The pipeline advance enable is decoded from registered occupancy only, so
// a full FIFO freezes every stage. That way a stalled result is captured
// exactly once.
module fpu_pipe_drain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fpu_pipe_drain_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // While frozen (full), pipe_valid_i is ignored because the stage output is held.
    assign push = !full && bus.pipe_valid_i;
    assign pop  = !empty && bus.res_ready_i;

    assign bus.pipe_en_o   = !full;
    assign bus.res_valid_o = !empty;
    assign bus.res_data_o  = mem[rd_ptr];
    assign bus.count_o     = count;

    // Result storage: written on capture. It has no reset, because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= bus.pipe_data_i;
        end
    end

    // Pointer and occupancy tracking. Flush and reset drop any push or pop made in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_pipe_drain.sv
// Directed bench for the FPU pipeline drain FIFO (WIDTH=32, DEPTH=4).
module tb_fpu_pipe_drain;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [WIDTH-1:0] exp_q[$];

    fpu_pipe_drain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fpu_pipe_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_valid_i = 1'b0;
        bus.pipe_data_i  = '0;
        bus.flush_i      = 1'b0;
        bus.res_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (bus.pipe_en_o !== 1'b1) begin n_fail++; $display("FAIL reset_pipe_en: got %b expected 1", bus.pipe_en_o); end
        n_checks++; if (bus.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid_o); end
        n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
    endtask

    task automatic test_stream();
        bus.res_ready_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.pipe_valid_i = 1'b1;
            bus.pipe_data_i  = WIDTH'(i);
            step();
            n_checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== WIDTH'(i)) begin n_fail++; $display("FAIL stream_data[%0d]: got v=%b d=%0h expected v=1 d=%0h", i, bus.res_valid_o, bus.res_data_o, i); end
            n_checks++; if (bus.count_o !== 3'd1 || bus.pipe_en_o !== 1'b1) begin n_fail++; $display("FAIL stream_occ[%0d]: got count=%0d en=%b expected count=1 en=1", i, bus.count_o, bus.pipe_en_o); end
        end
        bus.pipe_valid_i = 1'b0;
        step();
        n_checks++; if (bus.count_o !== 3'd0 || bus.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_end: got count=%0d v=%b expected count=0 v=0", bus.count_o, bus.res_valid_o); end
        idle_inputs();
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] vals [5];
        vals[0] = 32'hA0; vals[1] = 32'hA1; vals[2] = 32'hA2; vals[3] = 32'hA3; vals[4] = 32'hA4;
        bus.res_ready_i  = 1'b0;
        bus.pipe_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pipe_data_i = vals[i];
            step();
        end
        n_checks++; if (bus.count_o !== 3'd4 || bus.pipe_en_o !== 1'b0) begin n_fail++; $display("FAIL fill_full: got count=%0d en=%b expected count=4 en=0", bus.count_o, bus.pipe_en_o); end
        n_checks++; if (bus.res_data_o !== 32'hA0) begin n_fail++; $display("FAIL fill_head: got %0h expected a0", bus.res_data_o); end
        // A4 sits frozen at the pipeline output for two cycles
        bus.pipe_data_i = vals[4];
        step();
        step();
        n_checks++; if (bus.count_o !== 3'd4 || bus.pipe_en_o !== 1'b0) begin n_fail++; $display("FAIL fill_hold: got count=%0d en=%b expected count=4 en=0", bus.count_o, bus.pipe_en_o); end
        // Single pop: no capture on this edge, enable returns next cycle
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
        n_checks++; if (bus.count_o !== 3'd3 || bus.pipe_en_o !== 1'b1 || bus.res_data_o !== 32'hA1) begin n_fail++; $display("FAIL fill_pop: got count=%0d en=%b d=%0h expected count=3 en=1 d=a1", bus.count_o, bus.pipe_en_o, bus.res_data_o); end
        step();
        bus.pipe_valid_i = 1'b0;
        n_checks++; if (bus.count_o !== 3'd4 || bus.pipe_en_o !== 1'b0) begin n_fail++; $display("FAIL fill_capture: got count=%0d en=%b expected count=4 en=0", bus.count_o, bus.pipe_en_o); end
        for (int i = 1; i < 5; i++) exp_q.push_back(vals[i]);
        bus.res_ready_i = 1'b1;
        while (exp_q.size() != 0) begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            n_checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== e) begin n_fail++; $display("FAIL fill_drain: got v=%b d=%0h expected v=1 d=%0h", bus.res_valid_o, bus.res_data_o, e); end
            step();
        end
        n_checks++; if (bus.res_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin n_fail++; $display("FAIL fill_once: got v=%b count=%0d expected v=0 count=0", bus.res_valid_o, bus.count_o); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        bus.pipe_valid_i = 1'b1;
        bus.pipe_data_i  = 32'h11;
        step();
        bus.pipe_data_i  = 32'h22;
        step();
        n_checks++; if (bus.count_o !== 3'd2 || bus.res_data_o !== 32'h11) begin n_fail++; $display("FAIL simul_pre: got count=%0d d=%0h expected count=2 d=11", bus.count_o, bus.res_data_o); end
        bus.pipe_data_i  = 32'h55;
        bus.res_ready_i  = 1'b1;
        step();
        bus.pipe_valid_i = 1'b0;
        n_checks++; if (bus.count_o !== 3'd2 || bus.res_data_o !== 32'h22) begin n_fail++; $display("FAIL simul_both: got count=%0d d=%0h expected count=2 d=22", bus.count_o, bus.res_data_o); end
        step();
        n_checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h55) begin n_fail++; $display("FAIL simul_order: got v=%b d=%0h expected v=1 d=55", bus.res_valid_o, bus.res_data_o); end
        step();
        n_checks++; if (bus.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %b expected 0", bus.res_valid_o); end
        idle_inputs();
    endtask

    task automatic test_bubbles();
        logic       pat_v [4];
        logic [7:0] pat_d [4];
        pat_v[0] = 1'b1; pat_v[1] = 1'b0; pat_v[2] = 1'b1; pat_v[3] = 1'b0;
        pat_d[0] = 8'd7; pat_d[1] = 8'd8; pat_d[2] = 8'd9; pat_d[3] = 8'd10;
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd9);
        for (int i = 0; i < 4; i++) begin
            bus.pipe_valid_i = pat_v[i];
            bus.pipe_data_i  = WIDTH'(pat_d[i]);
            step();
        end
        bus.pipe_valid_i = 1'b0;
        n_checks++; if (bus.count_o !== 3'd2) begin n_fail++; $display("FAIL bubble_count: got %0d expected 2", bus.count_o); end
        bus.res_ready_i = 1'b1;
        while (exp_q.size() != 0) begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            n_checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== e) begin n_fail++; $display("FAIL bubble_data: got v=%b d=%0h expected v=1 d=%0h", bus.res_valid_o, bus.res_data_o, e); end
            step();
        end
        n_checks++; if (bus.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL bubble_empty: got %b expected 0", bus.res_valid_o); end
        idle_inputs();
    endtask

    task automatic test_flush();
        bus.pipe_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pipe_data_i = 32'h31 + WIDTH'(i);
            step();
        end
        n_checks++; if (bus.count_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %0d expected 3", bus.count_o); end
        bus.flush_i     = 1'b1;
        bus.res_ready_i = 1'b1;
        bus.pipe_data_i = 32'h34;
        step();
        idle_inputs();
        n_checks++; if (bus.count_o !== 3'd0 || bus.res_valid_o !== 1'b0 || bus.pipe_en_o !== 1'b1) begin n_fail++; $display("FAIL flush_state: got count=%0d v=%b en=%b expected 0/0/1", bus.count_o, bus.res_valid_o, bus.pipe_en_o); end
        step();
        n_checks++; if (bus.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_quiet: got %b expected 0", bus.res_valid_o); end
    endtask

    task automatic test_reset_stall();
        bus.pipe_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.pipe_data_i = 32'h41 + WIDTH'(i);
            step();
        end
        n_checks++; if (bus.pipe_en_o !== 1'b0 || bus.count_o !== 3'd4) begin n_fail++; $display("FAIL rst_stall_pre: got en=%b count=%0d expected en=0 count=4", bus.pipe_en_o, bus.count_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.pipe_valid_i = 1'b0;
        n_checks++; if (bus.pipe_en_o !== 1'b1 || bus.res_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin n_fail++; $display("FAIL rst_stall_state: got en=%b v=%b count=%0d expected 1/0/0", bus.pipe_en_o, bus.res_valid_o, bus.count_o); end
        bus.pipe_valid_i = 1'b1;
        bus.pipe_data_i  = 32'h3C;
        step();
        bus.pipe_valid_i = 1'b0;
        n_checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h3C || bus.count_o !== 3'd1) begin n_fail++; $display("FAIL rst_stall_first: got v=%b d=%0h count=%0d expected v=1 d=3c count=1", bus.res_valid_o, bus.res_data_o, bus.count_o); end
        bus.res_ready_i = 1'b1;
        step();
        n_checks++; if (bus.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall_drain: got %b expected 0", bus.res_valid_o); end
        idle_inputs();
    endtask

    // Scenario sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_fill();
        test_simultaneous();
        test_bubbles();
        test_flush();
        test_reset_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
